izhikevich_array: RTL and testbench

- Time-multiplexed array of NUM_NEURONS Izhikevich neurons that share one fixed-point datapath.
- Per-neuron v, w, input current and refractory counter are held in internal register arrays.
- A start pulse runs one sweep, advancing every neuron by one Euler step. Spikes leave on a valid/ready event stream for the downstream router or recorder.
- Successor to the single-neuron core: adds a neuron count, a refractory period, backpressure and state readback.

---
 rtl/izh_pkg.sv | 49 ++++
 rtl/izh_update_dp.sv | 32 +++
 rtl/izhikevich_array.sv | 186 ++++++++++++++++++
 tb/tb_izhikevich_array.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared fixed-point helpers, model constants and FSM encoding for the
// time-multiplexed Izhikevich neuron array.
package izh_pkg;

  localparam int IZH_N = 32;
  localparam int IZH_Q = 16;

  typedef logic signed [IZH_N-1:0] fx_t;

  localparam fx_t FX_MAX = {1'b0, {(IZH_N-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(IZH_N-1){1'b0}}};

  // Model constants rounded to the nearest Q-format value.
  localparam fx_t K_0P04 = fx_t'((4 * (1 << IZH_Q) + 50) / 100);
  localparam fx_t K_5    = fx_t'(5 << IZH_Q);
  localparam fx_t K_140  = fx_t'(140 << IZH_Q);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_WRITE,
    S_EMIT,
    S_DONE
  } state_t;

  function automatic fx_t sat_add(input fx_t x, input fx_t y);
    logic signed [IZH_N:0] s;
    s = {x[IZH_N-1], x} + {y[IZH_N-1], y};
    if (s[IZH_N] != s[IZH_N-1]) return s[IZH_N] ? FX_MIN : FX_MAX;
    return s[IZH_N-1:0];
  endfunction

  function automatic fx_t sat_sub(input fx_t x, input fx_t y);
    logic signed [IZH_N:0] s;
    s = {x[IZH_N-1], x} - {y[IZH_N-1], y};
    if (s[IZH_N] != s[IZH_N-1]) return s[IZH_N] ? FX_MIN : FX_MAX;
    return s[IZH_N-1:0];
  endfunction

  // Full-width product, arithmetic shift by q, then plain truncation.
  function automatic fx_t qmul(input fx_t x, input fx_t y, input int unsigned q);
    logic signed [2*IZH_N-1:0] p;
    p = (2*IZH_N)'(x) * (2*IZH_N)'(y);
    p = p >>> q;
    return p[IZH_N-1:0];
  endfunction

endpackage

// File: rtl/izh_update_dp.sv
// Combinational Euler increments dv/dw for one Izhikevich neuron.
module izh_update_dp
  import izh_pkg::*;
#(
  parameter int Q = IZH_Q
) (
  input  logic signed [IZH_N-1:0] v,
  input  logic signed [IZH_N-1:0] w,
  input  logic signed [IZH_N-1:0] i,
  input  logic signed [IZH_N-1:0] a,
  input  logic signed [IZH_N-1:0] b,
  input  logic signed [IZH_N-1:0] dv_step,
  input  logic signed [IZH_N-1:0] dw_step,
  output logic signed [IZH_N-1:0] dv,
  output logic signed [IZH_N-1:0] dw
);

  fx_t v_sq, poly, rec;

  always_comb begin
    v_sq = qmul(v, v, Q);
    poly = sat_add(qmul(K_0P04, v_sq, Q), qmul(K_5, v, Q));
    poly = sat_add(poly, K_140);
    poly = sat_sub(poly, w);
    poly = sat_add(poly, i);
    dv   = qmul(poly, dv_step, Q);

    rec  = sat_sub(qmul(b, v, Q), w);
    dw   = qmul(qmul(a, rec, Q), dw_step, Q);
  end

endmodule

// File: rtl/izhikevich_array.sv
// Array of Izhikevich neurons sharing one datapath; a sweep advances every
// neuron one Euler step and streams spike events out over valid/ready.
module izhikevich_array
  import izh_pkg::*;
#(
  parameter int N           = IZH_N,
  parameter int Q           = IZH_Q,
  parameter int NUM_NEURONS = 8,
  parameter int REFRACT_W   = 4,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [N-1:0]  v_init,
  input  logic signed [N-1:0]  w_init,
  input  logic                 init,
  input  logic signed [N-1:0]  a,
  input  logic signed [N-1:0]  b,
  input  logic signed [N-1:0]  c,
  input  logic signed [N-1:0]  d,
  input  logic signed [N-1:0]  v_th,
  input  logic signed [N-1:0]  dv_step,
  input  logic signed [N-1:0]  dw_step,
  input  logic [REFRACT_W-1:0] refract_len,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_addr,
  input  logic signed [N-1:0]  i_wr_data,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic signed [N-1:0]  rd_v,
  output logic signed [N-1:0]  rd_w,
  output logic                 spike_valid,
  output logic [IDX_W-1:0]     spike_idx,
  input  logic                 spike_ready,
  output logic                 busy,
  output logic                 done
);

  state_t               state, state_nx;
  logic [IDX_W-1:0]     idx, idx_nx;
  logic                 last, fire;

  fx_t                  v_mem  [NUM_NEURONS];
  fx_t                  w_mem  [NUM_NEURONS];
  fx_t                  i_mem  [NUM_NEURONS];
  logic [REFRACT_W-1:0] rc_mem [NUM_NEURONS];

  fx_t                  v_p0, w_p0, i_p0;
  logic [REFRACT_W-1:0] rc_p0;
  fx_t                  dv_c, dw_c, dv_p1, dw_p1;

  assign last = (idx == IDX_W'(NUM_NEURONS - 1));
  assign fire = (rc_p0 == '0) && (v_p0 > v_th);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      S_IDLE: begin
        if (start && !init) begin
          state_nx = S_LOAD;
          idx_nx   = '0;
        end
      end
      S_LOAD:  state_nx = S_CALC;
      S_CALC:  state_nx = S_WRITE;
      S_WRITE: begin
        if (fire) begin
          state_nx = S_EMIT;
        end else if (last) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_LOAD;
          idx_nx   = idx + 1'b1;
        end
      end
      S_EMIT: begin
        if (spike_ready) begin
          if (last) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_LOAD;
            idx_nx   = idx + 1'b1;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy        = (state == S_LOAD) || (state == S_CALC) ||
                       (state == S_WRITE) || (state == S_EMIT);
  assign done        = (state == S_DONE);
  assign spike_valid = (state == S_EMIT);
  assign spike_idx   = spike_valid ? idx : '0;

  // Neuron state and current memories: reset/init reload, WRITE commit, host writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem[k]  <= v_init;
        w_mem[k]  <= w_init;
        i_mem[k]  <= '0;
        rc_mem[k] <= '0;
      end
    end else begin
      if (state == S_IDLE && init) begin
        for (int k = 0; k < NUM_NEURONS; k++) begin
          v_mem[k]  <= v_init;
          w_mem[k]  <= w_init;
          rc_mem[k] <= '0;
        end
      end
      if (state == S_WRITE) begin
        if (rc_p0 != '0) begin
          rc_mem[idx] <= rc_p0 - 1'b1;
        end else if (fire) begin
          v_mem[idx]  <= c;
          w_mem[idx]  <= sat_add(w_p0, d);
          rc_mem[idx] <= refract_len;
        end else begin
          v_mem[idx]  <= sat_add(v_p0, dv_p1);
          w_mem[idx]  <= sat_add(w_p0, dw_p1);
        end
      end
      if (i_wr_en && (32'(i_wr_addr) < NUM_NEURONS)) begin
        i_mem[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // p0: operand fetch in LOAD
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      v_p0  <= v_mem[idx];
      w_p0  <= w_mem[idx];
      i_p0  <= i_mem[idx];
      rc_p0 <= rc_mem[idx];
    end
  end

  izh_update_dp #(.Q(Q)) u_dp (
    .v       (v_p0),
    .w       (w_p0),
    .i       (i_p0),
    .a       (a),
    .b       (b),
    .dv_step (dv_step),
    .dw_step (dw_step),
    .dv      (dv_c),
    .dw      (dw_c)
  );

  // p1: increments registered in CALC
  always_ff @(posedge clk) begin
    if (state == S_CALC) begin
      dv_p1 <= dv_c;
      dw_p1 <= dw_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v <= '0;
      rd_w <= '0;
    end else if (32'(rd_addr) < NUM_NEURONS) begin
      rd_v <= v_mem[rd_addr];
      rd_w <= w_mem[rd_addr];
    end else begin
      rd_v <= '0;
      rd_w <= '0;
    end
  end

endmodule

// File: tb/tb_izhikevich_array.sv
// Directed bench for izhikevich_array with hand-computed Q16.16 expectations.
module tb_izhikevich_array;

  localparam int NN = 8;

  logic        clk = 1'b0;
  logic        rst, start, init, i_wr_en, spike_ready;
  logic [31:0] v_init, w_init, a, b, c, d, v_th, dv_step, dw_step, i_wr_data;
  logic [3:0]  refract_len;
  logic [2:0]  i_wr_addr, rd_addr, spike_idx;
  logic [31:0] rd_v, rd_w;
  logic        spike_valid, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  izhikevich_array dut (
    .clk(clk), .rst(rst), .start(start), .v_init(v_init), .w_init(w_init),
    .init(init), .a(a), .b(b), .c(c), .d(d), .v_th(v_th),
    .dv_step(dv_step), .dw_step(dw_step), .refract_len(refract_len),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .rd_addr(rd_addr), .rd_v(rd_v), .rd_w(rd_w),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic read_state(input int addr, input logic [31:0] exp_v, input logic [31:0] exp_w);
    @(negedge clk);
    rd_addr = addr[2:0];
    @(negedge clk);
    check_eq($sformatf("rd_v[%0d]", addr), rd_v, exp_v);
    check_eq($sformatf("rd_w[%0d]", addr), rd_w, exp_w);
  endtask

  task automatic pulse_init();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Runs one sweep; optionally holds spike_ready low for 'stall' cycles at the first event.
  task automatic run_sweep(input int stall, output int cycles, output int nspk);
    int  stall_left;
    bit  prev_stalled;
    bit  seen_done;
    stall_left   = stall;
    prev_stalled = 0;
    seen_done    = 0;
    nspk         = 0;
    cycles       = 0;
    spike_ready  = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      start  = 1'b0;
      cycles = t;
      if (prev_stalled) check_eq("stall_valid_hold", {31'd0, spike_valid}, 32'd1);
      prev_stalled = 0;
      if (spike_valid) begin
        if (stall_left > 0) begin
          spike_ready = 1'b0;
          stall_left--;
          prev_stalled = 1;
          check_eq("stall_idx_hold", {29'd0, spike_idx}, nspk);
        end else begin
          spike_ready = 1'b1;
        end
        if (spike_ready) begin
          check_eq("spike_order", {29'd0, spike_idx}, nspk);
          nspk++;
        end
      end
      if (done) begin
        seen_done = 1;
        break;
      end
    end
    spike_ready = 1'b1;
    if (!seen_done) check_eq("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc, nspk, ndone, waited;
    rst = 1'b1; start = 1'b0; init = 1'b0; i_wr_en = 1'b0; spike_ready = 1'b1;
    v_init = 32'hFFBF0000; w_init = 32'hFFF30000;
    a = 32'h00010000; b = 32'h00004000;
    c = 32'hFFBF0000; d = 32'h00080000; v_th = 32'h001E0000;
    dv_step = 32'h00008000; dw_step = 32'h00008000;
    refract_len = 4'd0; i_wr_addr = 3'd0; i_wr_data = 32'd0; rd_addr = 3'd0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_valid", {31'd0, spike_valid}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_rd_v", rd_v, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < NN; k++) read_state(k, 32'hFFBF0000, 32'hFFF30000);

    // Sub-threshold step with i=10.0 on neuron 3
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_addr = 3'd3; i_wr_data = 32'h000A0000;
    @(negedge clk);
    i_wr_en = 1'b0;
    run_sweep(0, cyc, nspk);
    check_eq("sub_done_cycle", cyc, 32'd25);
    check_eq("sub_spikes", nspk, 32'd0);
    read_state(3, 32'hFFC27C5E, 32'hFFF16000);
    read_state(0, 32'hFFBD7C5E, 32'hFFF16000);
    read_state(7, 32'hFFBD7C5E, 32'hFFF16000);

    // Every neuron above threshold
    v_init = 32'h001F0000;
    pulse_init();
    read_state(5, 32'h001F0000, 32'hFFF30000);
    run_sweep(0, cyc, nspk);
    check_eq("spk_done_cycle", cyc, 32'd33);
    check_eq("spk_count", nspk, 32'd8);
    read_state(0, 32'hFFBF0000, 32'hFFFB0000);
    read_state(7, 32'hFFBF0000, 32'hFFFB0000);

    // Backpressure: 10 stalled cycles on the first event
    pulse_init();
    run_sweep(10, cyc, nspk);
    check_eq("bp_done_cycle", cyc, 32'd43);
    check_eq("bp_count", nspk, 32'd8);

    // Refractory period of two sweeps
    refract_len = 4'd2;
    pulse_init();
    run_sweep(0, cyc, nspk);
    check_eq("ref_s1_count", nspk, 32'd8);
    run_sweep(0, cyc, nspk);
    check_eq("ref_s2_count", nspk, 32'd0);
    check_eq("ref_s2_cycle", cyc, 32'd25);
    run_sweep(0, cyc, nspk);
    check_eq("ref_s3_count", nspk, 32'd0);
    read_state(0, 32'hFFBF0000, 32'hFFFB0000);
    read_state(3, 32'hFFBF0000, 32'hFFFB0000);

    // Reset while an event is pending
    refract_len = 4'd0;
    pulse_init();
    @(negedge clk);
    spike_ready = 1'b0;
    start = 1'b1;
    waited = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      start = 1'b0;
      waited = t;
      if (spike_valid) break;
    end
    check_eq("emit_reached", {31'd0, spike_valid}, 32'd1);
    check_eq("emit_idx", {29'd0, spike_idx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_emit_valid", {31'd0, spike_valid}, 32'd0);
    check_eq("rst_emit_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    spike_ready = 1'b1;
    check_eq("rst_emit_no_done", ndone, 32'd0);
    read_state(0, 32'h001F0000, 32'hFFF30000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
